// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer
//   Brings up a two-DCM clock chain (multiplier DCM, then phase-shift DCM)
//   and releases the core and DDR resets once both locks have been stable
//   for a settle window. Lost locks and lock timeouts restart the sequence.
//
// Ports
//   clk          raw board clock, free-running; the only clock of this block
//   rstN         asynchronous active-low reset
//   rstReq       debounced user reset request, active-high level, clk domain
//   mulLocked    multiplier DCM lock flag (asynchronous)
//   phaseLocked  phase-shift DCM lock flag (asynchronous)
//   mulRst       active-high reset to the multiplier DCM
//   phaseRst     active-high reset to the phase-shift DCM
//   sysRst       active-high core logic reset
//   memRst       active-high DDR interface reset (released STAGGER after sysRst)
//   ready        high once memRst has been released
//   fault        retry budget exhausted (only with CLK_SEQ_RETRY_LIMIT_EN)
//   retryCount   retry events since the last reset (only with CLK_SEQ_RETRY_LIMIT_EN)
//
// Build option
//   CLK_SEQ_RETRY_LIMIT_EN  defined: count retries, enter FAULT after MAX_RETRY.
//                           undefined: retry forever; fault and retryCount are 0.

module clk_rst_sequencer #(
  parameter int HOLD_CYCLES   = 3,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 256,
  parameter int STAGGER       = 16,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       rstReq,
  input  logic       mulLocked,
  input  logic       phaseLocked,
  output logic       mulRst,
  output logic       phaseRst,
  output logic       sysRst,
  output logic       memRst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retryCount
);

  // One shared counter serves as hold, timeout, settle and stagger counter;
  // it is cleared on every state entry, so one width covers all uses.
  localparam int MaxA   = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MaxB   = (SETTLE_CYCLES > STAGGER) ? SETTLE_CYCLES : STAGGER;
  localparam int CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int CW     = $clog2(CntMax + 1);

  localparam logic [CW-1:0] HoldEnd    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TimeoutEnd = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SettleEnd  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] StaggerEnd = CW'(STAGGER);

  typedef enum logic [2:0] {
    RST_MUL, WAIT_MUL, RST_PHASE, WAIT_PHASE, SETTLE, RUN, FAULT
  } seqState;

  seqState       state, stateNxt;
  logic [CW-1:0] cnt, cntNxt;
  logic [1:0]    mulSync, phaseSync;
  logic          mulLk, phaseLk, lost, retryEv;
  logic          mulRstNxt, phaseRstNxt, sysRstNxt, memRstNxt, readyNxt;

`ifdef CLK_SEQ_RETRY_LIMIT_EN
  // Clamp so a MAX_RETRY above the 4-bit saturation point never faults.
  localparam logic [4:0] FaultAt = (MAX_RETRY > 15) ? 5'd16 : 5'(MAX_RETRY);
  logic [3:0] retryCnt, retryNxt;
`endif

  // Lock flags come from the DCMs' own clock domains.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mulSync   <= 2'b00;
      phaseSync <= 2'b00;
    end else begin
      mulSync   <= {mulSync[0], mulLocked};
      phaseSync <= {phaseSync[0], phaseLocked};
    end
  end

  assign mulLk   = mulSync[1];
  assign phaseLk = phaseSync[1];
  assign lost    = !(mulLk && phaseLk);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= RST_MUL;
      cnt      <= '0;
      mulRst   <= 1'b1;
      phaseRst <= 1'b1;
      sysRst   <= 1'b1;
      memRst   <= 1'b1;
      ready    <= 1'b0;
`ifdef CLK_SEQ_RETRY_LIMIT_EN
      retryCnt <= 4'd0;
      fault    <= 1'b0;
`endif
    end else begin
      state    <= stateNxt;
      cnt      <= cntNxt;
      mulRst   <= mulRstNxt;
      phaseRst <= phaseRstNxt;
      sysRst   <= sysRstNxt;
      memRst   <= memRstNxt;
      ready    <= readyNxt;
`ifdef CLK_SEQ_RETRY_LIMIT_EN
      retryCnt <= retryNxt;
      fault    <= (stateNxt == FAULT);
`endif
    end
  end

  always_comb begin
    stateNxt = state;
    retryEv  = 1'b0;
`ifdef CLK_SEQ_RETRY_LIMIT_EN
    retryNxt = retryCnt;
`endif

    case (state)
      RST_MUL:    if (cnt == HoldEnd) stateNxt = WAIT_MUL;
      WAIT_MUL:   if (mulLk) stateNxt = RST_PHASE;
                  else if (cnt == TimeoutEnd) retryEv = 1'b1;
      RST_PHASE:  if (cnt == HoldEnd) stateNxt = WAIT_PHASE;
      WAIT_PHASE: if (phaseLk) stateNxt = SETTLE;
                  else if (cnt == TimeoutEnd) retryEv = 1'b1;
      SETTLE:     if (lost) retryEv = 1'b1;
                  else if (cnt == SettleEnd) stateNxt = RUN;
      RUN:        if (lost) retryEv = 1'b1;
      FAULT:      stateNxt = FAULT;
      default:    stateNxt = RST_MUL;
    endcase

    if (retryEv) begin
`ifdef CLK_SEQ_RETRY_LIMIT_EN
      retryNxt = (retryCnt == 4'hF) ? 4'hF : retryCnt + 4'd1;
      stateNxt = ({1'b0, retryNxt} >= FaultAt) ? FAULT : RST_MUL;
`else
      stateNxt = RST_MUL;
`endif
    end

    // User request overrides everything, including a same-cycle lock drop.
    if (rstReq) begin
      stateNxt = RST_MUL;
`ifdef CLK_SEQ_RETRY_LIMIT_EN
      retryNxt = 4'd0;
`endif
    end

    // rstReq re-enters RST_MUL even from RST_MUL, so it also clears the count.
    if (stateNxt != state || rstReq)
      cntNxt = '0;
    else if (state == FAULT || (state == RUN && cnt == StaggerEnd))
      cntNxt = cnt;
    else
      cntNxt = cnt + CW'(1);

    // Outputs are decoded from the next state so they register with it.
    mulRstNxt   = (stateNxt == RST_MUL) || (stateNxt == FAULT);
    phaseRstNxt = (stateNxt == RST_MUL) || (stateNxt == WAIT_MUL) ||
                  (stateNxt == RST_PHASE) || (stateNxt == FAULT);
    sysRstNxt   = (stateNxt != RUN);
    memRstNxt   = !((stateNxt == RUN) && (cntNxt == StaggerEnd));
    readyNxt    = !memRstNxt;
  end

`ifdef CLK_SEQ_RETRY_LIMIT_EN
  assign retryCount = retryCnt;
`else
  assign retryCount = 4'd0;
  assign fault      = 1'b0;
`endif

endmodule

// File: doc/clk_rst_sequencer.md
CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 3: clock cycles each DCM reset is held asserted (DCM minimum is 3 CLKIN cycles).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: maximum cycles to wait for a lock before a retry.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256: cycles both locks must stay high before system reset release.
REQ-004 SHALL have parameter STAGGER, default 16: cycles between sysRst release and memRst release.
REQ-005 SHALL have parameter MAX_RETRY, default 7: failed lock attempts tolerated before FAULT.
REQ-006 SHALL have ports: clk in 1, raw board clock, free-running; the block's one clock.
REQ-007 SHALL have port rstN in 1: asynchronous, active-low reset.
REQ-008 SHALL have port rstReq in 1: debounced user reset request, active-high level, synchronous to clk.
REQ-009 SHALL have ports mulLocked in 1 and phaseLocked in 1: DCM lock flags, asynchronous to clk.
REQ-010 SHALL have ports mulRst out 1 and phaseRst out 1: active-high resets to the multiplier and phase-shift DCMs.
REQ-011 SHALL have ports sysRst out 1 and memRst out 1: active-high resets for core logic and the DDR interface.
REQ-012 SHALL have ports ready out 1, fault out 1 and retryCount out 4.

Function
REQ-013 SHALL pass mulLocked and phaseLocked through two-flop synchronizers; all decisions use the synchronized values, which lag the inputs by 2 cycles.
REQ-014 SHALL implement states RST_MUL, WAIT_MUL, RST_PHASE, WAIT_PHASE, SETTLE, RUN and FAULT, with all outputs registered.
REQ-015 RST_MUL: mulRst=1 and phaseRst=1 for exactly HOLD_CYCLES cycles, then WAIT_MUL.
REQ-016 WAIT_MUL: mulRst=0 and phaseRst=1; on synchronized mulLocked, go to RST_PHASE; after LOCK_TIMEOUT cycles without lock, raise a retry event.
REQ-017 RST_PHASE: phaseRst=1 for HOLD_CYCLES cycles, then WAIT_PHASE with phaseRst=0.
REQ-018 WAIT_PHASE: on synchronized phaseLocked, go to SETTLE; a timeout raises a retry event.
REQ-019 SETTLE: count SETTLE_CYCLES cycles with both locks high, then RUN; a drop of either lock raises a retry event.
REQ-020 In every state except RUN, sysRst=1 and memRst=1.
REQ-021 RUN: sysRst=0 from the first RUN cycle; memRst=0 from STAGGER cycles later; ready=1 when memRst=0.
REQ-022 RUN: a drop of either synchronized lock SHALL assert sysRst, memRst and ready=0 on the next edge and raise a retry event.
REQ-023 A retry event SHALL increment retryCount, saturating at 15, and go to RST_MUL; if retryCount equals MAX_RETRY, it SHALL go to FAULT instead.
REQ-024 FAULT: all four resets=1 and fault=1; the block leaves FAULT only on rstN or rstReq.
REQ-025 rstReq=1 in any state SHALL force RST_MUL on the next edge and clear retryCount and fault.
REQ-026 While rstReq stays high, the block SHALL hold in RST_MUL with both DCM resets asserted.
REQ-027 The timeout, hold, settle and stagger counters SHALL clear on every state entry.
REQ-028 rstReq SHALL take priority over a lock drop occurring in the same cycle.

Reset
REQ-029 rstN=0 SHALL asynchronously force state RST_MUL, all counters 0, synchronizers 0, mulRst=phaseRst=sysRst=memRst=1, ready=0, fault=0 and retryCount=0.
REQ-030 After rstN deasserts, sequencing SHALL begin on the first clk edge.

Configuration
REQ-031 With macro CLK_SEQ_RETRY_LIMIT_EN defined, the block SHALL implement retry counting and the FAULT state per REQ-023/024.
REQ-032 Without CLK_SEQ_RETRY_LIMIT_EN, the block SHALL retry indefinitely, FAULT SHALL be unreachable, and fault and retryCount SHALL be tied to 0.

Verification (HOLD_CYCLES=3, LOCK_TIMEOUT=100, SETTLE_CYCLES=8, STAGGER=4, MAX_RETRY=2, macro defined)
REQ-033 Normal bring-up: release rstN, assert mulLocked 10 cycles later, then phaseLocked 10 cycles after mulRst falls -> mulRst high 3 cycles, phaseRst released after a further 3-cycle hold, sysRst falls 8 cycles after SETTLE entry, memRst and ready change 4 cycles later, retryCount=0.
REQ-034 mulLocked never asserts -> a retry after 100 WAIT_MUL cycles, retryCount=1, then 2 -> FAULT with fault=1 and all resets high; pulsing rstReq then returns to RST_MUL with retryCount=0.
REQ-035 In RUN, drop phaseLocked for 1 cycle -> sysRst, memRst=1 and ready=0 within 3 cycles of the drop, retryCount=1, then full re-sequence to RUN.
REQ-036 Drop a lock during SETTLE at count 5 -> return to RST_MUL and sysRst never deasserts.
REQ-037 Assert rstReq in the same cycle as a lock drop in RUN -> RST_MUL and retryCount=0; assert rstN=0 mid-WAIT_PHASE -> immediate reset values per REQ-029.
REQ-038 Rebuild without the macro, with mulLocked held low for 1000 cycles -> repeated 103-cycle retry loops, and fault and retryCount stay 0.
